// File: rtl/pic_core_pkg.sv
// pic_core_pkg
//   Shared types, constants and helpers for the pic_core_nch interrupt
//   controller core and its priority resolver.
//   - eoi_kind_e   : non-specific / specific end-of-interrupt
//   - IMR_RST      : reset value of the mask register (all lines masked),
//                    sized for the widest supported core; slice as needed
//   - bottom_rst() : reset value of the lowest-priority index (line 0 top)
//   - idx2onehot / onehot2idx : conversions for vectors up to MAX_IRQ wide;
//                    callers size-cast to their own NUM_IRQ / ID_W
package pic_core_pkg;

    localparam int MAX_IRQ  = 32;
    localparam int MAX_ID_W = 5;

    typedef enum logic {
        EOI_NONSPEC = 1'b0,
        EOI_SPEC    = 1'b1
    } eoi_kind_e;

    localparam logic [MAX_IRQ-1:0] IMR_RST = '1;

    // Bottom = NUM_IRQ-1 makes line 0 the highest priority after reset.
    function automatic logic [MAX_ID_W-1:0] bottom_rst(input int num_irq);
        return MAX_ID_W'(num_irq - 1);
    endfunction

    function automatic logic [MAX_IRQ-1:0] idx2onehot(input logic [MAX_ID_W-1:0] idx);
        return MAX_IRQ'(1) << idx;
    endfunction

    // Caller guarantees at most one bit is set; zero maps to index 0.
    function automatic logic [MAX_ID_W-1:0] onehot2idx(input logic [MAX_IRQ-1:0] oh);
        logic [MAX_ID_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_IRQ; i++) begin
            if (oh[i]) r = r | MAX_ID_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// pic_prio_resolver
//   Combinational rotating priority encoder. The line just above `bottom`
//   (mod NUM_IRQ) has the highest priority, `bottom` itself the lowest.
//   Ports:
//     req    in  NUM_IRQ  request vector
//     bottom in  ID_W     current lowest-priority index (must be < NUM_IRQ)
//     valid  out 1        any request present
//     id     out ID_W     index of the highest-priority request
module pic_prio_resolver
    import pic_core_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [ID_W-1:0]    bottom,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    logic [NUM_IRQ-1:0] gnt;
    int                 idx;

    // Walk from lowest to highest priority so the last hit left in gnt is
    // the winner; bottom < NUM_IRQ so one conditional subtract is the modulo.
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int k = NUM_IRQ; k >= 1; k--) begin
            idx = int'(bottom) + k;
            if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
            if (req[ID_W'(idx)]) gnt = NUM_IRQ'(idx2onehot(MAX_ID_W'(idx)));
        end
        valid = |req;
        id    = ID_W'(onehot2idx(MAX_IRQ'(gnt)));
    end

endmodule

// File: rtl/pic_core_nch.sv
// pic_core_nch
//   Programmable interrupt controller core for NUM_IRQ request lines:
//   IRR/ISR/IMR, rotating priority, CPU request/acknowledge/vector
//   handshake, specific and non-specific EOI, auto-EOI, auto-rotate.
//   Ports:
//     clock, reset                  clock, synchronous active-high reset
//     irq_in                        synchronised request lines
//     cfg_level/auto_eoi/auto_rotate trigger mode and service options
//     vector_base                   vec_out = vector_base + id (wraps)
//     mask_wr, mask_data            IMR load strobe / value
//     eoi_valid, eoi_specific, eoi_id   end-of-interrupt command
//     rot_set_valid, rot_set_id     set lowest-priority line
//     int_req, int_ack              CPU request / acknowledge
//     vec_valid, vec_out            acknowledged vector (one-cycle pulse)
//     irr, isr, imr                 register readback
//   Optional (macro PIC_CORE_POLL_EN): poll_rd / poll_word polled
//   acknowledge returning {1, zero pad, id}, or 0 if nothing pending.
module pic_core_nch
    import pic_core_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_level,
    input  logic               cfg_auto_eoi,
    input  logic               cfg_auto_rotate,
    input  logic [VEC_W-1:0]   vector_base,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic [ID_W-1:0]    eoi_id,
    input  logic               rot_set_valid,
    input  logic [ID_W-1:0]    rot_set_id,
    output logic               int_req,
    input  logic               int_ack,
    output logic               vec_valid,
    output logic [VEC_W-1:0]   vec_out,
`ifdef PIC_CORE_POLL_EN
    input  logic               poll_rd,
    output logic [VEC_W-1:0]   poll_word,
`endif
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] imr
);

    localparam logic [ID_W-1:0] BOTTOM_RST = ID_W'(bottom_rst(NUM_IRQ));

    logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [ID_W-1:0]    bottom_q, bottom_d;
    logic               int_req_q, int_req_d;
    logic               vec_valid_q, vec_valid_d;
    logic [VEC_W-1:0]   vec_out_q, vec_out_d;
`ifdef PIC_CORE_POLL_EN
    logic [VEC_W-1:0]   poll_word_q, poll_word_d;
`endif

    logic               pend_valid, isr_valid;
    logic [ID_W-1:0]    pend_id, isr_id;
    logic               ack_any, take, eoi_hit;
    logic [ID_W-1:0]    eoi_svc;
    logic [NUM_IRQ-1:0] win_oh, eoi_clr;

    // Arbitration always sees the registered IMR, so a same-cycle mask
    // write only affects the next cycle.
    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_pend_res (
        .req    (irr_q & ~imr_q),
        .bottom (bottom_q),
        .valid  (pend_valid),
        .id     (pend_id)
    );

    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
        .req    (isr_q),
        .bottom (bottom_q),
        .valid  (isr_valid),
        .id     (isr_id)
    );

    // Distance from the top of the priority ring; smaller outranks larger.
    function automatic int rank(input logic [ID_W-1:0] id, input logic [ID_W-1:0] bot);
        int d;
        d = int'(id) - int'(bot) - 1;
        if (d < 0) d = d + NUM_IRQ;
        return d;
    endfunction

    always_comb begin
        ack_any = int_ack;
`ifdef PIC_CORE_POLL_EN
        ack_any = int_ack | poll_rd;
`endif
        take   = ack_any & pend_valid;
        win_oh = NUM_IRQ'(idx2onehot(MAX_ID_W'(pend_id)));

        // Request register: new edges/levels first, then the acknowledge clear.
        irq_prev_d = irq_in;
        irr_d = cfg_level ? irq_in : (irr_q | (irq_in & ~irq_prev_q));
        if (take) irr_d = irr_d & ~win_oh;

        // EOI is a no-op with nothing in service or an out-of-range target.
        eoi_hit = 1'b0;
        eoi_svc = isr_id;
        if (eoi_valid && isr_valid) begin
            if (eoi_kind_e'(eoi_specific) == EOI_SPEC) begin
                if (int'(eoi_id) < NUM_IRQ) begin
                    eoi_hit = 1'b1;
                    eoi_svc = eoi_id;
                end
            end else begin
                eoi_hit = 1'b1;
            end
        end
        eoi_clr = eoi_hit ? NUM_IRQ'(idx2onehot(MAX_ID_W'(eoi_svc))) : '0;

        // EOI clears before the acknowledge sets, so both on one line leave it set.
        isr_d = isr_q & ~eoi_clr;
        if (take && !cfg_auto_eoi) isr_d = isr_d | win_oh;

        imr_d = mask_wr ? mask_data : imr_q;

        // Later assignments win: EOI rotate, then auto-EOI rotate, then explicit set.
        bottom_d = bottom_q;
        if (cfg_auto_rotate && eoi_hit) bottom_d = eoi_svc;
        if (cfg_auto_rotate && take && cfg_auto_eoi) bottom_d = pend_id;
        if (rot_set_valid && int'(rot_set_id) < NUM_IRQ) bottom_d = rot_set_id;

        int_req_d = 1'b0;
        if (!ack_any && pend_valid)
            int_req_d = !isr_valid || (rank(pend_id, bottom_q) < rank(isr_id, bottom_q));

        vec_valid_d = int_ack;
        vec_out_d   = vec_out_q;
        if (int_ack)
            vec_out_d = vector_base + (take ? VEC_W'(pend_id) : VEC_W'(NUM_IRQ - 1));

`ifdef PIC_CORE_POLL_EN
        poll_word_d = '0;
        if (poll_rd && !int_ack && pend_valid)
            poll_word_d = {1'b1, (VEC_W-1)'(pend_id)};
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irr_q       <= '0;
            isr_q       <= '0;
            imr_q       <= NUM_IRQ'(IMR_RST);
            irq_prev_q  <= '0;
            bottom_q    <= BOTTOM_RST;
            int_req_q   <= 1'b0;
            vec_valid_q <= 1'b0;
            vec_out_q   <= '0;
`ifdef PIC_CORE_POLL_EN
            poll_word_q <= '0;
`endif
        end else begin
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            irq_prev_q  <= irq_prev_d;
            bottom_q    <= bottom_d;
            int_req_q   <= int_req_d;
            vec_valid_q <= vec_valid_d;
            vec_out_q   <= vec_out_d;
`ifdef PIC_CORE_POLL_EN
            poll_word_q <= poll_word_d;
`endif
        end
    end

    assign irr       = irr_q;
    assign isr       = isr_q;
    assign imr       = imr_q;
    assign int_req   = int_req_q;
    assign vec_valid = vec_valid_q;
    assign vec_out   = vec_out_q;
`ifdef PIC_CORE_POLL_EN
    assign poll_word = poll_word_q;
`endif

endmodule

// File: tb/tb_pic_core_nch.sv
module tb_pic_core_nch;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] irq_in, mask_data, vector_base;
    logic       cfg_level, cfg_auto_eoi, cfg_auto_rotate, mask_wr;
    logic       eoi_valid, eoi_specific, rot_set_valid, int_ack;
    logic [2:0] eoi_id, rot_set_id;
    logic       int_req, vec_valid;
    logic [7:0] vec_out, irr, isr, imr;

    logic [15:0] irq16, mask_data16, irr16, isr16, imr16;
    logic        mask_wr16, int_ack16, int_req16, vec_valid16;
    logic [3:0]  eoi_id16, rot_set_id16;
    logic [7:0]  vec_out16;
`ifdef PIC_CORE_POLL_EN
    logic       poll_rd, poll_rd16;
    logic [7:0] poll_word, poll_word16;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clock = ~clock;

    pic_core_nch #(.NUM_IRQ(8), .VEC_W(8)) u_dut8 (
        .clock(clock), .reset(reset), .irq_in(irq_in), .cfg_level(cfg_level),
        .cfg_auto_eoi(cfg_auto_eoi), .cfg_auto_rotate(cfg_auto_rotate),
        .vector_base(vector_base), .mask_wr(mask_wr), .mask_data(mask_data),
        .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_id(eoi_id),
        .rot_set_valid(rot_set_valid), .rot_set_id(rot_set_id),
        .int_req(int_req), .int_ack(int_ack), .vec_valid(vec_valid), .vec_out(vec_out),
`ifdef PIC_CORE_POLL_EN
        .poll_rd(poll_rd), .poll_word(poll_word),
`endif
        .irr(irr), .isr(isr), .imr(imr)
    );

    pic_core_nch #(.NUM_IRQ(16), .VEC_W(8)) u_dut16 (
        .clock(clock), .reset(reset), .irq_in(irq16), .cfg_level(cfg_level),
        .cfg_auto_eoi(cfg_auto_eoi), .cfg_auto_rotate(cfg_auto_rotate),
        .vector_base(vector_base), .mask_wr(mask_wr16), .mask_data(mask_data16),
        .eoi_valid(eoi_valid), .eoi_specific(eoi_specific), .eoi_id(eoi_id16),
        .rot_set_valid(rot_set_valid), .rot_set_id(rot_set_id16),
        .int_req(int_req16), .int_ack(int_ack16), .vec_valid(vec_valid16), .vec_out(vec_out16),
`ifdef PIC_CORE_POLL_EN
        .poll_rd(poll_rd16), .poll_word(poll_word16),
`endif
        .irr(irr16), .isr(isr16), .imr(imr16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Scoreboard: every vec_valid pulse of the 8-line core must match the
    // oldest expected vector.
    always @(posedge clock) begin
        #2;
        if (vec_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL vec_pulse: unexpected vec_valid vec_out=%0h", vec_out);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("vec_out", {24'd0, vec_out}, {24'd0, mon_exp});
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        irq_in = '0; mask_data = '0; vector_base = '0; mask_wr = 1'b0;
        cfg_level = 1'b0; cfg_auto_eoi = 1'b0; cfg_auto_rotate = 1'b0;
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id = '0;
        rot_set_valid = 1'b0; rot_set_id = '0; int_ack = 1'b0;
        irq16 = '0; mask_data16 = '0; mask_wr16 = 1'b0; int_ack16 = 1'b0;
        eoi_id16 = '0; rot_set_id16 = '0;
`ifdef PIC_CORE_POLL_EN
        poll_rd = 1'b0; poll_rd16 = 1'b0;
`endif
        tick(2);
        reset = 1'b0;
    endtask

    task automatic set_mask(input logic [7:0] m);
        mask_wr = 1'b1; mask_data = m;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic ack(input logic [7:0] exp_vec);
        int_ack = 1'b1;
        exp_q.push_back(exp_vec);
        tick();
        int_ack = 1'b0;
    endtask

    typedef struct {
        logic       lvl;
        logic       aeoi;
        logic [7:0] imr;
        logic [7:0] irq;
        logic [7:0] base;
        logic [7:0] vec;
        logic [7:0] isr;
        logic [7:0] irr;
        logic       req;
    } vec_t;

    vec_t tbl[8];

    initial begin
        //            lvl   aeoi  imr    irq    base   vec    isr    irr    req
        tbl[0] = '{1'b0, 1'b0, 8'h00, 8'h24, 8'h40, 8'h42, 8'h04, 8'h20, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 8'h04, 8'h24, 8'h40, 8'h45, 8'h20, 8'h04, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 8'h81, 8'h10, 8'h10, 8'h01, 8'h80, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 8'hff, 8'h0f, 8'h20, 8'h27, 8'h00, 8'h0f, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hfe, 8'h05, 8'h00, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h7f, 8'h80, 8'hfa, 8'h01, 8'h80, 8'h00, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 8'hf0, 8'hf8, 8'h00, 8'h03, 8'h08, 8'hf0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 8'h02, 8'h30, 8'h31, 8'h00, 8'h00, 1'b1};

        // Reset state
        do_reset();
        chk("rst_imr", imr, 8'hff);
        chk("rst_isr", isr, 8'h00);
        chk("rst_irr", irr, 8'h00);
        chk("rst_int_req", int_req, 1'b0);
        chk("rst_vec_valid", vec_valid, 1'b0);
        chk("rst_vec_out", vec_out, 8'h00);
        chk("rst_imr16", imr16, 16'hffff);

        // Table: single acknowledge under varied mode / mask / base
        foreach (tbl[i]) begin
            do_reset();
            cfg_level = tbl[i].lvl; cfg_auto_eoi = tbl[i].aeoi; vector_base = tbl[i].base;
            set_mask(tbl[i].imr);
            irq_in = tbl[i].irq;
            tick(2);
            chk($sformatf("t%0d_int_req", i), int_req, tbl[i].req);
            ack(tbl[i].vec);
            chk($sformatf("t%0d_isr", i), isr, tbl[i].isr);
            chk($sformatf("t%0d_irr", i), irr, tbl[i].irr);
            chk($sformatf("t%0d_req_drop", i), int_req, 1'b0);
        end

        // Nesting: lower-priority pending stays blocked until non-specific EOI
        do_reset();
        vector_base = 8'h40;
        set_mask(8'h00);
        irq_in = 8'h24;
        tick(2);
        ack(8'h42);
        tick();
        chk("nest_blocked", int_req, 1'b0);
        eoi_valid = 1'b1; eoi_specific = 1'b0;
        tick();
        eoi_valid = 1'b0;
        chk("nest_eoi_isr", isr, 8'h00);
        tick();
        chk("nest_req_after_eoi", int_req, 1'b1);
        ack(8'h45);
        chk("nest_isr2", isr, 8'h20);

        // Auto-rotate: serviced line 0 becomes lowest priority
        do_reset();
        vector_base = 8'h40; cfg_auto_rotate = 1'b1;
        set_mask(8'h00);
        irq_in = 8'h09;
        tick(2);
        ack(8'h40);
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_id = 3'd0;
        tick();
        eoi_valid = 1'b0; eoi_specific = 1'b0;
        chk("rot_eoi_isr", isr, 8'h00);
        irq_in = 8'h08; tick();
        irq_in = 8'h09; tick(2);
        ack(8'h43);
        chk("rot_isr", isr, 8'h08);
        chk("rot_irr", irr, 8'h01);
        // Explicit set (bottom=7) beats the same-cycle auto-rotate (bottom=3)
        eoi_valid = 1'b1; rot_set_valid = 1'b1; rot_set_id = 3'd7;
        tick();
        eoi_valid = 1'b0; rot_set_valid = 1'b0;
        irq_in = 8'h49; tick(2);
        ack(8'h40);
        chk("rotset_isr", isr, 8'h01);

        // Spurious acknowledge leaves ISR untouched
        do_reset();
        vector_base = 8'h40;
        set_mask(8'h00);
        irq_in = 8'h04;
        tick(2);
        ack(8'h42);
        set_mask(8'hff);
        ack(8'h47);
        chk("spur_isr", isr, 8'h04);
        chk("spur_irr", irr, 8'h00);

        // EOI and acknowledge of the same line in one cycle
        do_reset();
        vector_base = 8'h40;
        set_mask(8'h00);
        irq_in = 8'h02;
        tick(2);
        ack(8'h41);
        irq_in = 8'h00; tick();
        irq_in = 8'h02; tick(2);
        eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_id = 3'd1;
        ack(8'h41);
        eoi_valid = 1'b0; eoi_specific = 1'b0;
        chk("same_isr", isr, 8'h02);
        chk("same_irr", irr, 8'h00);
        tick(3);

        // 16-line core: vector wraps modulo 2^VEC_W
        do_reset();
        vector_base = 8'hf8;
        mask_wr16 = 1'b1; mask_data16 = 16'h0000; tick(); mask_wr16 = 1'b0;
        irq16 = 16'h1000;
        tick(2);
        chk("w16_int_req", int_req16, 1'b1);
        int_ack16 = 1'b1; tick(); int_ack16 = 1'b0;
        chk("w16_vec_valid", vec_valid16, 1'b1);
        chk("w16_vec_out", vec_out16, 8'h04);
        chk("w16_isr", isr16, 16'h1000);
`ifdef PIC_CORE_POLL_EN
        irq16 = 16'h0000; tick();
        irq16 = 16'h1000; tick(2);
        poll_rd16 = 1'b1; tick(); poll_rd16 = 1'b0;
        chk("poll_word", poll_word16, 8'h8c);
        chk("poll_no_vec", vec_valid16, 1'b0);
        chk("poll_irr", irr16, 16'h0000);
        tick();
        chk("poll_idle", poll_word16, 8'h00);
`endif

        // Every expected vector must have been observed, within a bound
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
